cis_line_sequencer: RTL and testbench
=====================================

Name: cis_line_sequencer

Overview:
- Timing master for the contact-image-sensor scan: produces the sensor start pulse (CIS_SP) and per-color LED enables, and runs the R->G->B line schedule.
- Drives COLOR_TOGGLE/COLOR_CNT into the ADC capture path, which resynchronises them into the ADC clock domain.
- Counts RGB lines, stops after a programmed line count, and pauses at triplet boundaries while the downstream FIFO is almost full.

Parameters:
- LINE_PERIOD, 3000: clocks per single-color line. Must be > SP_WIDTH and >= LED_ON_DELAY+LED_ON_TIME.
- SP_WIDTH, 4: CIS_SP high time in clocks, >= 1.
- LED_ON_DELAY, 100: clocks from line start to LED on.
- LED_ON_TIME, 2700: LED on time in clocks, >= 1.
- CNT_W, 16: width of LINES_NUM and the line counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- START  in  1  level; high in IDLE begins a scan; low requests stop
- LINES_NUM  in  CNT_W  RGB triplets to capture; 0 = continuous; latched when leaving IDLE
- AFULL  in  1  downstream almost-full; sampled at triplet end
- CIS_SP  out  1  sensor start pulse
- LED_R / LED_G / LED_B  out  1 each  LED enables
- COLOR_TOGGLE  out  1  inverts at the start of every color line
- COLOR_CNT  out  2  color of the current line: 0=R, 1=G, 2=B
- LINE_DONE  out  1  one-cycle pulse at the end of each completed RGB triplet
- BUSY  out  1  high in LINE and WAIT

Behaviour:
- All outputs are registered. Reset values: every output 0, COLOR_TOGGLE 0, COLOR_CNT 0, state IDLE, counters 0.
- RST has priority at any point, including mid-line. Outputs reach reset values on the cycle after the RST edge.
- States: IDLE, LINE, WAIT, DONE.
- IDLE -> LINE when START=1. The first LINE cycle follows the sampling edge (1-cycle latency).
- On IDLE -> LINE: latch LINES_NUM, tcnt=0, COLOR_CNT=0, pcnt=0, invert COLOR_TOGGLE.
- In LINE, pcnt counts 0..LINE_PERIOD-1. Cycle pcnt=0 is the first cycle of a color line.
- CIS_SP=1 while pcnt < SP_WIDTH.
- LED_x=1 only for the LED matching COLOR_CNT, while LED_ON_DELAY <= pcnt < LED_ON_DELAY+LED_ON_TIME. All LEDs are 0 outside LINE.
- COLOR_TOGGLE inverts, and COLOR_CNT takes its new value, in the same cycle that pcnt returns to 0. Both stay stable for the whole line.
- End of line (pcnt=LINE_PERIOD-1), COLOR_CNT 0 or 1: the next cycle starts the next color line (COLOR_CNT+1, toggle).
- End of line, COLOR_CNT=2 (triplet end): LINE_DONE=1 for one cycle (the first cycle after the blue line) and tcnt increments, saturating at all-ones. Next state, first match wins:
  1. LINES_NUM!=0 and tcnt+1==LINES_NUM -> DONE.
  2. START=0 -> IDLE.
  3. AFULL=1 -> WAIT.
  4. Otherwise next red line (COLOR_CNT=0, toggle).
- START deasserting mid-triplet has no immediate effect. The current triplet always completes, so the downstream capture never gets a partial RGB pixel.
- WAIT: no SP, LEDs off, COLOR_TOGGLE held.
  - AFULL=0 and START=1 -> LINE (red line; its first cycle follows the sampling edge).
  - START=0 -> IDLE.
- DONE: BUSY=0. Stays in DONE while START=1, so a held START does not retrigger; START=0 -> IDLE.
- COLOR_CNT value 3 is never produced.
- COLOR_TOGGLE is never inverted twice within LINE_PERIOD. This guarantees the receiving edge detector sees each edge after synchroniser delay.
- LINES_NUM changes after latching are ignored until the next IDLE exit.

Optional Feature:
- Macro: CIS_MONO_EN.
- Defined: monochrome mode. COLOR_CNT is fixed at 1, only LED_G is driven, and a "triplet" is one line. LINE_DONE pulses, tcnt advances and AFULL is sampled at the end of every line. COLOR_TOGGLE still inverts each line.
- Undefined: RGB sequencing exactly as in Behaviour.

Test Plan:
- Params LINE_PERIOD=100, SP_WIDTH=4, LED_ON_DELAY=10, LED_ON_TIME=50 throughout.
- LINES_NUM=2, START held high -> 6 toggle inversions 100 cycles apart; COLOR_CNT 0,1,2,0,1,2; CIS_SP high 4 cycles per line; LINE_DONE pulses at cycles 300 and 600 after start; DONE entered, BUSY=0; no restart until START low then high.
- Green line observed -> LED_G high exactly at pcnt 10..59; LED_R and LED_B low throughout the line.
- LINES_NUM=0, AFULL=1 from cycle 250 to 420 -> after the blue line ends (cycle 300), WAIT with no SP; next red line (toggle, CIS_SP) on the cycle after AFULL samples 0.
- LINES_NUM=0, START dropped during green (cycle 150) -> blue line still completes; LINE_DONE at cycle 300; then IDLE; exactly 3 toggle inversions total.
- RST pulsed at pcnt=30 of the red line -> next cycle all outputs 0, COLOR_TOGGLE 0, state IDLE; START high restarts at COLOR_CNT 0.
- CIS_MONO_EN defined, LINES_NUM=3 -> 3 lines; COLOR_CNT=1 always; only LED_G toggles; 3 LINE_DONE pulses; then DONE.

Source files
------------

// File: rtl/cis_line_sequencer.sv
// Contact-image-sensor line timing master: start pulse, LED enables and the R->G->B line schedule.
// Optional macro CIS_MONO_EN selects monochrome mode (green only, one line per "triplet").
module cis_line_sequencer #(
  parameter int LINE_PERIOD  = 3000,
  parameter int SP_WIDTH     = 4,
  parameter int LED_ON_DELAY = 100,
  parameter int LED_ON_TIME  = 2700,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] LINES_NUM,
  input  logic             AFULL,
  output logic             CIS_SP,
  output logic             LED_R,
  output logic             LED_G,
  output logic             LED_B,
  output logic             COLOR_TOGGLE,
  output logic [1:0]       COLOR_CNT,
  output logic             LINE_DONE,
  output logic             BUSY
);

  localparam int PW = $clog2(LINE_PERIOD + 1);
  localparam logic [PW-1:0] LAST_PCNT = PW'(LINE_PERIOD - 1);
  localparam logic [PW-1:0] SP_END    = PW'(SP_WIDTH);
  localparam logic [PW-1:0] LED_START = PW'(LED_ON_DELAY);
  localparam logic [PW-1:0] LED_END   = PW'(LED_ON_DELAY + LED_ON_TIME);
`ifdef CIS_MONO_EN
  localparam logic [1:0] FIRST_COLOR = 2'd1;
`else
  localparam logic [1:0] FIRST_COLOR = 2'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_WAIT, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    pcnt_reg, pcnt_next;
  logic [1:0]       color_reg, color_next;
  logic             toggle_reg, toggle_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic [CNT_W-1:0] lines_reg, lines_next;
  logic [CNT_W:0]   tcnt_inc;
  logic             triplet_end;
  logic             start_red;
  logic             done_next, done_reg;
  logic             sp_next, sp_reg;
  logic             busy_next, busy_reg;
  logic             led_window;
  logic [2:0]       led_next, led_reg;

  assign tcnt_inc = {1'b0, tcnt_reg} + {{CNT_W{1'b0}}, 1'b1};

`ifdef CIS_MONO_EN
  assign triplet_end = 1'b1;
`else
  assign triplet_end = (color_reg == 2'd2);
`endif

  always_comb begin
    state_next  = state_reg;
    pcnt_next   = pcnt_reg;
    color_next  = color_reg;
    toggle_next = toggle_reg;
    tcnt_next   = tcnt_reg;
    lines_next  = lines_reg;
    done_next   = 1'b0;
    start_red   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          lines_next = LINES_NUM;
          tcnt_next  = '0;
          start_red  = 1'b1;
        end
      end
      S_LINE: begin
        if (pcnt_reg != LAST_PCNT) begin
          pcnt_next = pcnt_reg + {{(PW-1){1'b0}}, 1'b1};
        end else if (!triplet_end) begin
          pcnt_next   = '0;
          color_next  = color_reg + 2'd1;
          toggle_next = ~toggle_reg;
        end else begin
          // A triplet only ends here, so stop/pause requests never split an RGB pixel.
          done_next = 1'b1;
          tcnt_next = (&tcnt_reg) ? tcnt_reg : tcnt_inc[CNT_W-1:0];
          pcnt_next = '0;
          if ((lines_reg != '0) && (tcnt_inc == {1'b0, lines_reg})) begin
            state_next = S_DONE;
          end else if (!START) begin
            state_next = S_IDLE;
          end else if (AFULL) begin
            state_next = S_WAIT;
          end else begin
            start_red = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (START && !AFULL) begin
          start_red = 1'b1;
        end else if (!START) begin
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        if (!START) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (start_red) begin
      state_next  = S_LINE;
      pcnt_next   = '0;
      color_next  = FIRST_COLOR;
      toggle_next = ~toggle_reg;
    end
  end

  // Outputs are decoded from next-state values so the registered outputs line up with the state.
  assign busy_next  = (state_next == S_LINE) || (state_next == S_WAIT);
  assign sp_next    = (state_next == S_LINE) && (pcnt_next < SP_END);
  assign led_window = (state_next == S_LINE) && (pcnt_next >= LED_START) && (pcnt_next < LED_END);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_led
      assign led_next[gi] = led_window && (color_next == 2'(gi));
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      pcnt_reg   <= '0;
      color_reg  <= 2'd0;
      toggle_reg <= 1'b0;
      tcnt_reg   <= '0;
      lines_reg  <= '0;
      done_reg   <= 1'b0;
      sp_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      led_reg    <= 3'b000;
    end else begin
      state_reg  <= state_next;
      pcnt_reg   <= pcnt_next;
      color_reg  <= color_next;
      toggle_reg <= toggle_next;
      tcnt_reg   <= tcnt_next;
      lines_reg  <= lines_next;
      done_reg   <= done_next;
      sp_reg     <= sp_next;
      busy_reg   <= busy_next;
      led_reg    <= led_next;
    end
  end

  assign CIS_SP       = sp_reg;
  assign LED_R        = led_reg[0];
  assign LED_G        = led_reg[1];
  assign LED_B        = led_reg[2];
  assign COLOR_TOGGLE = toggle_reg;
  assign COLOR_CNT    = color_reg;
  assign LINE_DONE    = done_reg;
  assign BUSY         = busy_reg;

endmodule

// File: tb/tb_cis_line_sequencer.sv
// Self-checking bench for cis_line_sequencer: directed scan scenarios plus random episodes
// compared cycle by cycle against a scan-level reference model.
module tb_cis_line_sequencer;

  localparam int LP  = 100;
  localparam int SPW = 4;
  localparam int LD  = 10;
  localparam int LT  = 50;
  localparam int CW  = 16;
  localparam int TRIP_MAX = (1 << CW) - 1;
`ifdef CIS_MONO_EN
  localparam int PER_TRIP = 1;
  localparam int FIRST    = 1;
  localparam int R_PER    = 0;
  localparam int S1_LINES = 3;
`else
  localparam int PER_TRIP = 3;
  localparam int FIRST    = 0;
  localparam int R_PER    = 1;
  localparam int S1_LINES = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [CW-1:0] LINES_NUM = '0;
  logic          AFULL = 1'b0;
  logic          CIS_SP, LED_R, LED_G, LED_B, COLOR_TOGGLE, LINE_DONE, BUSY;
  logic [1:0]    COLOR_CNT;

  cis_line_sequencer #(
    .LINE_PERIOD(LP), .SP_WIDTH(SPW), .LED_ON_DELAY(LD), .LED_ON_TIME(LT), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .LINES_NUM(LINES_NUM), .AFULL(AFULL),
    .CIS_SP(CIS_SP), .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .COLOR_TOGGLE(COLOR_TOGGLE), .COLOR_CNT(COLOR_CNT), .LINE_DONE(LINE_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: scan mode 0 idle, 1 scanning, 2 waiting, 3 done.
  int m_mode = 0, m_phase = 0, m_line = 0, m_trip = 0, m_target = 0, m_color = 0;
  bit m_tog = 1'b0, m_pulse = 1'b0;

  task automatic begin_triplet();
    m_mode  = 1;
    m_phase = 0;
    m_line  = 0;
    m_tog   = !m_tog;
    m_color = FIRST;
  endtask

  task automatic model_update();
    m_pulse = 1'b0;
    if (RST) begin
      m_mode = 0; m_phase = 0; m_line = 0; m_trip = 0;
      m_target = 0; m_tog = 1'b0; m_color = 0;
    end else begin
      case (m_mode)
        0: if (START) begin
             m_target = int'(LINES_NUM);
             m_trip   = 0;
             begin_triplet();
           end
        1: if (m_phase < LP - 1) begin
             m_phase++;
           end else if (m_line < PER_TRIP - 1) begin
             m_line++;
             m_phase = 0;
             m_tog   = !m_tog;
             m_color = m_line;
           end else begin
             m_pulse = 1'b1;
             if (m_trip < TRIP_MAX) m_trip++;
             if (m_target != 0 && m_trip == m_target) m_mode = 3;
             else if (!START) m_mode = 0;
             else if (AFULL) m_mode = 2;
             else begin_triplet();
           end
        2: if (!START) m_mode = 0;
           else if (!AFULL) begin_triplet();
        default: if (!START) m_mode = 0;
      endcase
    end
  endtask

  int   cnt_tog, cnt_done, cnt_g, cnt_r, cyc, first_done;
  logic prev_tog = 1'b0;

  task automatic clear_counts();
    cnt_tog = 0; cnt_done = 0; cnt_g = 0; cnt_r = 0; cyc = 0; first_done = -1;
  endtask

  function automatic logic [8:0] dut_vec();
    return {CIS_SP, LED_R, LED_G, LED_B, COLOR_TOGGLE, COLOR_CNT, LINE_DONE, BUSY};
  endfunction

  task automatic step();
    logic [8:0] exp_v;
    logic       led_on, sp;
    @(posedge CLK);
    model_update();
    #1;
    sp     = (m_mode == 1) && (m_phase < SPW);
    led_on = (m_mode == 1) && (m_phase >= LD) && (m_phase < LD + LT);
    exp_v  = {sp, led_on && m_color == 0, led_on && m_color == 1, led_on && m_color == 2,
              m_tog, 2'(m_color), m_pulse, (m_mode == 1) || (m_mode == 2)};
    check("outputs", 32'(dut_vec()), 32'(exp_v));
    if (COLOR_TOGGLE !== prev_tog) cnt_tog++;
    prev_tog = COLOR_TOGGLE;
    if (LINE_DONE === 1'b1) begin
      cnt_done++;
      if (first_done < 0) first_done = cyc;
    end
    cnt_g += int'(LED_G);
    cnt_r += int'(LED_R);
    cyc++;
  endtask

  initial begin
    clear_counts();
    repeat (3) step();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    RST = 1'b0;
    step();

    // Fixed line count with START held: stop in DONE, no retrigger.
    LINES_NUM = CW'(S1_LINES);
    START = 1'b1;
    clear_counts();
    repeat (800) step();
    check("s1_toggles", 32'(cnt_tog), 32'(S1_LINES * PER_TRIP));
    check("s1_done_pulses", 32'(cnt_done), 32'(S1_LINES));
    check("s1_first_done_cycle", 32'(first_done), 32'(LP * PER_TRIP));
    check("s1_busy", 32'(BUSY), 32'd0);
    check("s1_led_g_cycles", 32'(cnt_g), 32'(LT * S1_LINES));
    check("s1_led_r_cycles", 32'(cnt_r), 32'(LT * S1_LINES * R_PER));
    $display("scan lines=%0d: toggles=%0d done=%0d first_done=%0d", S1_LINES, cnt_tog, cnt_done, first_done);
    START = 1'b0;
    step();
    START = 1'b1;
    clear_counts();
    repeat (5) step();
    check("s1_restart_toggle", 32'(cnt_tog), 32'd1);
    $display("restart after START low/high: toggles=%0d", cnt_tog);

    // Continuous scan paused by AFULL.
    START = 1'b0;
    repeat (400) step();
    LINES_NUM = '0;
    START = 1'b1;
    clear_counts();
    for (int c = 0; c < 700; c++) begin
      AFULL = (c >= 250 && c < 420);
      step();
    end
    START = 1'b0;
    repeat (400) step();
    check("afull_end_idle", 32'(BUSY), 32'd0);
    $display("afull pause scan: toggles=%0d done=%0d", cnt_tog, cnt_done);

    // START dropped mid-triplet: current triplet completes.
    START = 1'b1;
    clear_counts();
    repeat (150) step();
    START = 1'b0;
    repeat (400) step();
    check("stop_toggles", 32'(cnt_tog), 32'(PER_TRIP == 3 ? 3 : 2));
    check("stop_done_pulses", 32'(cnt_done), 32'(PER_TRIP == 3 ? 1 : 2));
    check("stop_first_done_cycle", 32'(first_done), 32'(LP * PER_TRIP));
    $display("mid-scan stop: toggles=%0d done=%0d", cnt_tog, cnt_done);

    // Reset in the middle of the first line.
    LINES_NUM = CW'(5);
    START = 1'b1;
    clear_counts();
    repeat (31) step();
    RST = 1'b1;
    step();
    check("midline_reset_outputs", 32'(dut_vec()), 32'd0);
    RST = 1'b0;
    repeat (150) step();
    START = 1'b0;
    repeat (400) step();
    $display("mid-line reset and restart: toggles=%0d", cnt_tog);

    // Random episodes.
    for (int ep = 0; ep < 12; ep++) begin
      int n;
      LINES_NUM = CW'($urandom_range(0, 3));
      START = 1'b1;
      clear_counts();
      n = $urandom_range(200, 1200);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 59) == 0) AFULL = ~AFULL;
        if ($urandom_range(0, 99) == 0) LINES_NUM = CW'($urandom);
        if ($urandom_range(0, 499) == 0) START = ~START;
        RST = ($urandom_range(0, 1999) == 0);
        step();
      end
      START = 1'b0;
      AFULL = 1'b0;
      RST = 1'b0;
      repeat (400) step();
      check("episode_end_idle", 32'(BUSY), 32'd0);
      $display("episode %0d: cycles=%0d toggles=%0d done=%0d", ep, n, cnt_tog, cnt_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
